// File: rtl/weak_bus_ram.sv
// Word-organised RAM target for the weakcore single-master bus.
// Byte-lane writes, configurable wait states, sticky out-of-range fault flag.
module weak_bus_ram #(
   parameter int unsigned ADDR_WIDTH  = 10,
   parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
   parameter int unsigned WAIT_CYCLES = 1,
   parameter              INIT_FILE   = ""
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        bus_req,
   input  logic [31:0] bus_addr,
   input  logic        bus_wr,
   input  logic [3:0]  bus_wr_mask,
   input  logic [31:0] bus_in,
   output logic [31:0] bus_out,
   output logic        bus_ack,
   output logic        fault
);

   localparam int unsigned DEPTH = 1 << ADDR_WIDTH;

   typedef enum logic [1:0] {
      S_IDLE,
      S_WAIT,
      S_ACK
   } state_t;

   state_t      state_q, state_d;
   logic [3:0]  cnt_q, cnt_d;
   logic [31:0] addr_q, addr_d;
   logic        wr_q, wr_d;
   logic [3:0]  mask_q, mask_d;
   logic [31:0] data_q, data_d;
   logic [31:0] out_q;
   logic        fault_q;

   logic        acc_en;
   logic        acc_wr;
   logic [31:0] acc_addr;
   logic [3:0]  acc_mask;
   logic [31:0] acc_data;
   logic [31:0] acc_off;
   logic        acc_in_range;
   logic [ADDR_WIDTH-1:0] acc_idx;
   logic        unused_off_bits;

   logic [31:0] mem_q [DEPTH];

   // With zero wait states the access happens on the capture edge, so it
   // must use the live bus inputs rather than the latched copies.
   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      addr_d   = addr_q;
      wr_d     = wr_q;
      mask_d   = mask_q;
      data_d   = data_q;
      acc_en   = 1'b0;
      acc_wr   = wr_q;
      acc_addr = addr_q;
      acc_mask = mask_q;
      acc_data = data_q;
      case (state_q)
         S_IDLE: begin
            if (bus_req) begin
               addr_d = bus_addr;
               wr_d   = bus_wr;
               mask_d = bus_wr_mask;
               data_d = bus_in;
               cnt_d  = 4'(WAIT_CYCLES);
               if (WAIT_CYCLES == 0) begin
                  acc_en   = 1'b1;
                  acc_wr   = bus_wr;
                  acc_addr = bus_addr;
                  acc_mask = bus_wr_mask;
                  acc_data = bus_in;
                  state_d  = S_ACK;
               end else begin
                  state_d = S_WAIT;
               end
            end
         end
         S_WAIT: begin
            cnt_d = cnt_q - 4'd1;
            if (cnt_q <= 4'd1) begin
               acc_en  = 1'b1;
               state_d = S_ACK;
            end
         end
         S_ACK:   state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   assign acc_off         = acc_addr - BASE_ADDR;
   assign acc_in_range    = (acc_off >> (ADDR_WIDTH + 2)) == '0;
   assign acc_idx         = acc_off[ADDR_WIDTH+1:2];
   assign unused_off_bits = ^acc_off[1:0];

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
         addr_q  <= '0;
         wr_q    <= 1'b0;
         mask_q  <= '0;
         data_q  <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         addr_q  <= addr_d;
         wr_q    <= wr_d;
         mask_q  <= mask_d;
         data_q  <= data_d;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         out_q   <= '0;
         fault_q <= 1'b0;
      end else if (acc_en) begin
         if (!acc_in_range) begin
            fault_q <= 1'b1;
         end
         if (!acc_wr) begin
            out_q <= acc_in_range ? mem_q[acc_idx] : '0;
         end
      end
   end

   // Storage has no reset; a reset on the access edge cancels the write.
   always_ff @(posedge clk) begin
      if (!rst && acc_en && acc_wr && acc_in_range) begin
         for (int unsigned i = 0; i < 4; i++) begin
            if (acc_mask[i]) begin
               mem_q[acc_idx][8*i +: 8] <= acc_data[8*i +: 8];
            end
         end
      end
   end

   assign bus_out = out_q;
   assign bus_ack = (state_q == S_ACK);
   assign fault   = fault_q;

endmodule

// File: tb/tb_weak_bus_ram.sv
// Bench for weak_bus_ram: four instances with WAIT_CYCLES 0..3 share clk/rst;
// table-driven transactions via a scoreboard queue plus hand-written corner sequences.
module tb_weak_bus_ram;

   logic        clk = 1'b0;
   logic        rst;
   logic        req   [4];
   logic [31:0] addr  [4];
   logic        wr    [4];
   logic [3:0]  mask  [4];
   logic [31:0] din   [4];
   logic [31:0] dout  [4];
   logic        ack   [4];
   logic        fault [4];

   always #5 clk = ~clk;

   generate
      for (genvar g = 0; g < 4; g++) begin : g_dut
         weak_bus_ram #(
            .ADDR_WIDTH (10),
            .BASE_ADDR  (32'h0000_0000),
            .WAIT_CYCLES(g),
            .INIT_FILE  ("")
         ) u_dut (
            .clk        (clk),
            .rst        (rst),
            .bus_req    (req[g]),
            .bus_addr   (addr[g]),
            .bus_wr     (wr[g]),
            .bus_wr_mask(mask[g]),
            .bus_in     (din[g]),
            .bus_out    (dout[g]),
            .bus_ack    (ack[g]),
            .fault      (fault[g])
         );
      end
   endgenerate

   typedef struct {
      logic        wr;
      logic [31:0] addr;
      logic [3:0]  mask;
      logic [31:0] data;
      logic [31:0] exp_rd;
      logic        exp_fault;
   } vec_t;

   typedef struct {
      int unsigned inst;
      logic [31:0] out;
      logic        fault;
      int unsigned lat;
   } exp_t;

   vec_t        vecs [15];
   exp_t        sb_q [$];
   logic [31:0] last_rd [4];
   int          checks = 0;
   int          errors = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
      end
   endtask

   task automatic txn(input int unsigned n, input logic w, input logic [31:0] a,
                      input logic [3:0] m, input logic [31:0] d,
                      input logic [31:0] exp_rd, input logic exp_f);
      exp_t        e;
      int unsigned cyc;
      logic        seen;
      e.inst  = n;
      e.out   = w ? last_rd[n] : exp_rd;
      e.fault = exp_f;
      e.lat   = n + 1;
      @(negedge clk);
      req[n]  = 1'b1;
      wr[n]   = w;
      addr[n] = a;
      mask[n] = m;
      din[n]  = d;
      sb_q.push_back(e);
      cyc  = 0;
      seen = 1'b0;
      while (!seen && cyc < 40) begin
         @(negedge clk);
         cyc++;
         if (ack[n]) seen = 1'b1;
      end
      req[n] = 1'b0;
      e = sb_q.pop_front();
      if (!seen) begin
         checks++;
         errors++;
         $display("FAIL timeout inst%0d addr 0x%08h: no ack within %0d cycles, ack required", n, a, cyc);
      end else begin
         check($sformatf("latency inst%0d addr 0x%08h", e.inst, a), cyc, e.lat);
         check($sformatf("bus_out inst%0d %s 0x%08h", e.inst, w ? "SW" : "LW", a), dout[n], e.out);
         check($sformatf("fault inst%0d addr 0x%08h", e.inst, a), 32'(fault[n]), 32'(e.fault));
         if (!w) last_rd[n] = exp_rd;
         @(negedge clk);
         check($sformatf("ack single pulse inst%0d addr 0x%08h", e.inst, a), 32'(ack[n]), 32'h0);
      end
   endtask

   initial begin
      vecs[0]  = '{1'b1, 32'h0000_0010, 4'hF,    32'hDEAD_BEEF, 32'h0,         1'b0};
      vecs[1]  = '{1'b0, 32'h0000_0010, 4'h0,    32'h0,         32'hDEAD_BEEF, 1'b0};
      vecs[2]  = '{1'b0, 32'h0000_0013, 4'h0,    32'h0,         32'hDEAD_BEEF, 1'b0};
      vecs[3]  = '{1'b1, 32'h0000_0020, 4'hF,    32'h1122_3344, 32'h0,         1'b0};
      vecs[4]  = '{1'b1, 32'h0000_0020, 4'b0010, 32'h0000_AB00, 32'h0,         1'b0};
      vecs[5]  = '{1'b0, 32'h0000_0020, 4'h0,    32'h0,         32'h1122_AB44, 1'b0};
      vecs[6]  = '{1'b1, 32'h0000_0020, 4'b1100, 32'hCDEF_0000, 32'h0,         1'b0};
      vecs[7]  = '{1'b0, 32'h0000_0020, 4'h0,    32'h0,         32'hCDEF_AB44, 1'b0};
      vecs[8]  = '{1'b1, 32'h0000_0000, 4'hF,    32'hA5A5_0001, 32'h0,         1'b0};
      vecs[9]  = '{1'b1, 32'h0000_0FFC, 4'hF,    32'h1234_5678, 32'h0,         1'b0};
      vecs[10] = '{1'b0, 32'h0000_0FFC, 4'h0,    32'h0,         32'h1234_5678, 1'b0};
      vecs[11] = '{1'b0, 32'h0000_1000, 4'h0,    32'h0,         32'h0,         1'b1};
      vecs[12] = '{1'b1, 32'h0000_1000, 4'hF,    32'hFFFF_FFFF, 32'h0,         1'b1};
      vecs[13] = '{1'b0, 32'h0000_0000, 4'h0,    32'h0,         32'hA5A5_0001, 1'b1};
      vecs[14] = '{1'b0, 32'h0000_0010, 4'h0,    32'h0,         32'hDEAD_BEEF, 1'b1};

      for (int i = 0; i < 4; i++) begin
         req[i] = 1'b0; wr[i] = 1'b0; addr[i] = '0; mask[i] = '0; din[i] = '0;
         last_rd[i] = '0;
      end

      // Reset held two cycles with a pending write on the WAIT_CYCLES=1 instance
      rst = 1'b1;
      req[1] = 1'b1; wr[1] = 1'b1; addr[1] = 32'h0; mask[1] = 4'hF; din[1] = 32'h0;
      for (int k = 0; k < 2; k++) begin
         @(negedge clk);
         check($sformatf("reset ack cyc%0d", k), 32'(ack[1]), 32'h0);
         check($sformatf("reset bus_out cyc%0d", k), dout[1], 32'h0);
         check($sformatf("reset fault cyc%0d", k), 32'(fault[1]), 32'h0);
      end
      rst = 1'b0;
      begin
         int unsigned cyc;
         cyc = 0;
         while (!ack[1] && cyc < 40) begin
            @(negedge clk);
            cyc++;
         end
         check("first ack after reset latency", cyc, 32'd2);
         check("first ack bus_out after write", dout[1], 32'h0);
      end
      req[1] = 1'b0;
      @(negedge clk);

      for (int unsigned n = 0; n < 4; n++) begin
         for (int v = 0; v < 15; v++) begin
            txn(n, vecs[v].wr, vecs[v].addr, vecs[v].mask, vecs[v].data,
                vecs[v].exp_rd, vecs[v].exp_fault);
         end
      end

      @(negedge clk) rst = 1'b1;
      @(negedge clk) rst = 1'b0;
      for (int i = 0; i < 4; i++) begin
         check($sformatf("fault cleared by rst inst%0d", i), 32'(fault[i]), 32'h0);
         check($sformatf("bus_out cleared by rst inst%0d", i), dout[i], 32'h0);
         last_rd[i] = '0;
      end

      // WAIT_CYCLES=3 with request held: acks 5 cycles apart; drop mid-transaction still acks
      @(negedge clk);
      req[3] = 1'b1; wr[3] = 1'b0; addr[3] = 32'h10; mask[3] = '0;
      for (int k = 1; k <= 24; k++) begin
         logic exp_ack;
         @(negedge clk);
         exp_ack = (k == 4) || (k == 9) || (k == 14) || (k == 19);
         check($sformatf("held req ack cyc%0d", k), 32'(ack[3]), 32'(exp_ack));
         if (ack[3]) check($sformatf("held req bus_out cyc%0d", k), dout[3], 32'hDEAD_BEEF);
         if (k == 16) req[3] = 1'b0;
      end
      last_rd[3] = 32'hDEAD_BEEF;

      // WAIT_CYCLES=2: reset in first WAIT cycle cancels the write
      txn(2, 1'b1, 32'h40, 4'hF, 32'h0102_0304, 32'h0, 1'b0);
      @(negedge clk);
      req[2] = 1'b1; wr[2] = 1'b1; addr[2] = 32'h40; mask[2] = 4'hF; din[2] = 32'h55AA_55AA;
      @(negedge clk);
      check("abort ack in WAIT", 32'(ack[2]), 32'h0);
      rst = 1'b1;
      @(negedge clk);
      check("abort ack during rst", 32'(ack[2]), 32'h0);
      rst = 1'b0;
      req[2] = 1'b0;
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         check($sformatf("abort no ack cyc%0d", k), 32'(ack[2]), 32'h0);
      end
      last_rd[2] = '0;
      txn(2, 1'b0, 32'h40, 4'h0, 32'h0, 32'h0102_0304, 1'b0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
